// File: rtl/arb_pkg.sv
// Shared constants and types for the 4-requester round-robin arbiter.
package arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;
    localparam int CNT_W   = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Result of a round-robin search: whether anyone was found, and who.
    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

endpackage

// File: rtl/Decoder_2x4_dataflow.sv
// Plain 2-to-4 one-hot decoder, dataflow style; S1 is the MSB of the select.
module Decoder_2x4_dataflow (
    input  logic       S0,
    input  logic       S1,
    output logic [3:0] m
);

    assign m[0] = ~S1 & ~S0;
    assign m[1] = ~S1 &  S0;
    assign m[2] =  S1 & ~S0;
    assign m[3] =  S1 &  S0;

endmodule

// File: rtl/rr_arbiter_4req.sv
// Four-way round-robin arbiter with a bounded hold time: an owner keeps the
// grant while it requests, but yields after MAX_HOLD cycles if anyone waits.
module rr_arbiter_4req
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid
);

    if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_bad_max_hold
        $error("rr_arbiter_4req: MAX_HOLD must be in 1..15");
    end

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    // First set bit of r at or after start, wrapping modulo NUM_REQ. Walking
    // the offsets downward lets the nearest candidate overwrite the others.
    function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] r,
                                      input logic [IDX_W-1:0]   start);
        pick_t            p;
        logic [IDX_W-1:0] cand;
        p = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = start + IDX_W'(i);
            if (r[cand]) begin
                p.found = 1'b1;
                p.idx   = cand;
            end
        end
        return p;
    endfunction

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   ptr_q,   ptr_d;
    logic [CNT_W-1:0]   hold_q,  hold_d;

    logic [NUM_REQ-1:0] owner_oh;
    logic [NUM_REQ-1:0] others;
    logic               owner_req;
    pick_t              pick_any;
    pick_t              pick_other;
    logic               install;
    logic [IDX_W-1:0]   win_idx;

    Decoder_2x4_dataflow u_dec (
        .S0 (owner_q[0]),
        .S1 (owner_q[1]),
        .m  (owner_oh)
    );

    // Outputs come straight from state registers; req never reaches them.
    assign gnt_valid = (state_q == BUSY);
    assign gnt_idx   = owner_q;
    assign gnt       = owner_oh & {NUM_REQ{gnt_valid}};

    assign others     = req & ~owner_oh;
    assign owner_req  = |(req & owner_oh);
    assign pick_any   = rr_pick(req, ptr_q);
    assign pick_other = rr_pick(others, ptr_q);

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        install = 1'b0;
        win_idx = '0;

        case (state_q)
            IDLE: begin
                if (pick_any.found) begin
                    install = 1'b1;
                    win_idx = pick_any.idx;
                end
            end
            BUSY: begin
                if (!owner_req) begin
                    if (pick_other.found) begin
                        install = 1'b1;
                        win_idx = pick_other.idx;
                    end else begin
                        state_d = IDLE;
                        owner_d = '0;
                        hold_d  = '0;
                    end
                end else if (hold_q == HOLD_LAST && pick_other.found) begin
                    install = 1'b1;
                    win_idx = pick_other.idx;
                end else if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (install) begin
            state_d = BUSY;
            owner_d = win_idx;
            ptr_d   = win_idx + IDX_W'(1);
            hold_d  = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// File: doc/rr_arbiter_4req.md
RR_ARBITER_4REQ -- requirements
Module: rr_arbiter_4req

Interface
REQ-001 Parameter MAX_HOLD, default 4, is the maximum consecutive grant cycles while another requester waits; the legal range SHALL be 1..15.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 req  input  4  level request per requester; bit i is requester i.
REQ-005 gnt  output  4  one-hot grant, all zeros when no grant.
REQ-006 gnt_idx  output  2  binary index of current owner; 0 when gnt_valid=0.
REQ-007 gnt_valid  output  1  high while any grant is active.

Function
REQ-008 The FSM SHALL have two states, IDLE (no owner) and BUSY (owner = gnt_idx).
REQ-009 Arbitration SHALL be round-robin: search req from pointer ptr upward, modulo 4; the first set bit wins.
REQ-010 ptr SHALL be set to (winner+1) mod 4 on every edge that installs a new owner.
REQ-011 In IDLE with req != 0 at an edge, the winner SHALL be installed at that edge: state BUSY, gnt_valid=1, hold_cnt=0, giving 1-cycle request-to-grant latency.
REQ-012 In IDLE with req == 0, all outputs SHALL hold their reset values.
REQ-013 In BUSY, owner req low at an edge with other requests pending SHALL install the next round-robin winner at that same edge, with no idle bubble.
REQ-014 In BUSY, owner req low at an edge with no other request SHALL return the FSM to IDLE, with gnt=0, gnt_valid=0, gnt_idx=0 from that edge.
REQ-015 In BUSY with owner req high, hold_cnt SHALL increment each edge, saturating at MAX_HOLD-1.
REQ-016 If hold_cnt == MAX_HOLD-1 at an edge, the owner req is high, and any other req is high, the grant SHALL pass to the next round-robin winner (preemption), excluding the current owner.
REQ-017 With no other req pending, the owner SHALL keep the grant indefinitely, with hold_cnt saturated.
REQ-018 gnt SHALL equal the 2:4 decode of gnt_idx ANDed with gnt_valid, so that at most one bit is ever set.
REQ-019 gnt, gnt_idx and gnt_valid SHALL be driven from registers or from a decode of registers only, with no combinational path from req.
REQ-020 hold_cnt SHALL be 4 bits wide; ptr SHALL be 2 bits wide, and its wrap from 3 to 0 is natural modulo.

Reset
REQ-021 Assertion of rst_n low SHALL immediately force state=IDLE, ptr=0, hold_cnt=0, gnt=0, gnt_idx=0 and gnt_valid=0, including mid-grant.
REQ-022 After rst_n deasserts, the first arbitration SHALL start from ptr=0.

Structure
REQ-023 A shared package arb_pkg SHALL hold NUM_REQ=4, IDX_W=2, CNT_W=4 and the FSM state enum {IDLE, BUSY}.
REQ-024 The one-hot gnt SHALL be produced by one instance of Decoder_2x4_dataflow (S0=gnt_idx[0], S1=gnt_idx[1]), with its m output gated by gnt_valid.
REQ-025 The round-robin selection SHALL be a combinational function inside rr_arbiter_4req, not a separate module.

Verification
REQ-026 The bench SHALL cover reset then req=4'b0100 for 1 cycle -> next edge gnt=4'b0100, gnt_idx=2, gnt_valid=1; ptr becomes 3.
REQ-027 The bench SHALL cover req=4'b1111 held with MAX_HOLD=4 -> grants 0,1,2,3,0, each lasting exactly 4 cycles, with no gap cycles.
REQ-028 The bench SHALL cover owner 1 dropping req while req=4'b1001 -> the same edge grants 3 (gnt=4'b1000); 0 follows after preemption or release.
REQ-029 The bench SHALL cover req=4'b0010 alone held for 20 cycles -> gnt=4'b0010 for all 20 cycles, with no preemption.
REQ-030 The bench SHALL cover rst_n pulsed low mid-grant -> gnt=0 and gnt_valid=0 without waiting for a clock edge; with req=4'b1010 after release, the next edge grants 1.
REQ-031 The bench SHALL cover random req for 10k cycles, checking with assertions that gnt is onehot0, that gnt_valid == |gnt, and that no requester waits more than 3*MAX_HOLD+3 cycles.
